// File: rtl/flop_add_pipe_if.sv
// flop_add_pipe_if: request/result valid-ready bundle for flop_add_pipe
interface flop_add_pipe_if #(parameter int MANT_W = 8, EXP_W = 4, TAG_W = 4);
  localparam int W = 1 + MANT_W + EXP_W;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_res;
  logic [TAG_W-1:0] out_tag;
  logic             out_ovf;
  logic             out_unf;
  logic             out_zero;
  modport master (
    output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag, out_ovf, out_unf, out_zero
  );
  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag, out_ovf, out_unf, out_zero
  );
endinterface

// File: rtl/flop_add_pipe.sv
// flop_add_pipe: three-stage add/subtract pipeline for packed {sign,mant,exp} floats
module flop_add_pipe #(
  parameter int MANT_W = 8,
  parameter int EXP_W  = 4,
  parameter int TAG_W  = 4
) (
  input logic           clk,
  input logic           reset,
  flop_add_pipe_if.slave bus
);
  localparam int W    = 1 + MANT_W + EXP_W;
  localparam int LZ_W = $clog2(MANT_W + 1);
  localparam int CW   = (LZ_W > EXP_W) ? LZ_W : EXP_W;
  logic              w_adv;
  logic              w_a_s, w_b_s, w_a_big;
  logic [MANT_W-1:0] w_a_m, w_b_m, w_m_big, w_m_small, w_aligned;
  logic [EXP_W-1:0]  w_a_e, w_b_e, w_e_big, w_e_small, w_d;
  logic              r1_valid, r1_sign, r1_match;
  logic [MANT_W-1:0] r1_m_big, r1_aligned;
  logic [EXP_W-1:0]  r1_e_big;
  logic [TAG_W-1:0]  r1_tag;
  logic [MANT_W:0]   w_sum;
  logic              r2_valid, r2_sign;
  logic [MANT_W:0]   r2_sum;
  logic [EXP_W-1:0]  r2_e_big;
  logic [TAG_W-1:0]  r2_tag;
  logic [CW-1:0]     w_lz;
  logic              w_exact, w_ovf, w_unf;
  logic [W-1:0]      w_res;
  assign w_adv        = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = w_adv;
  assign w_a_s     = bus.in_a[W-1];
  assign w_a_m     = bus.in_a[W-2:EXP_W];
  assign w_a_e     = bus.in_a[EXP_W-1:0];
  assign w_b_s     = bus.in_b[W-1] ^ bus.in_sub;
  assign w_b_m     = bus.in_b[W-2:EXP_W];
  assign w_b_e     = bus.in_b[EXP_W-1:0];
  assign w_a_big   = {w_a_e, w_a_m} >= {w_b_e, w_b_m};
  assign w_m_big   = w_a_big ? w_a_m : w_b_m;
  assign w_m_small = w_a_big ? w_b_m : w_a_m;
  assign w_e_big   = w_a_big ? w_a_e : w_b_e;
  assign w_e_small = w_a_big ? w_b_e : w_a_e;
  assign w_d       = w_e_big - w_e_small;
  assign w_aligned = (32'(w_d) >= MANT_W) ? '0 : w_m_small >> w_d;
  assign w_sum = r1_match ? {1'b0, r1_m_big} + {1'b0, r1_aligned}
                          : {1'b0, r1_m_big} - {1'b0, r1_aligned};
  always_comb begin
    w_lz = CW'(MANT_W);
    for (int i = 0; i < MANT_W; i++)
      if (r2_sum[i]) w_lz = CW'(MANT_W - 1 - i);
    w_exact = r2_sum == '0;
    w_ovf   = r2_sum[MANT_W] & (&r2_e_big);
    w_unf   = ~w_exact & ~r2_sum[MANT_W] & (w_lz > CW'(r2_e_big));
    w_res   = (w_exact | w_unf) ? '0 :
              w_ovf             ? {r2_sign, {(W-1){1'b1}}} :
              r2_sum[MANT_W]    ? {r2_sign, r2_sum[MANT_W:1], r2_e_big + EXP_W'(1)} :
                                  {r2_sign, r2_sum[MANT_W-1:0] << w_lz, r2_e_big - EXP_W'(w_lz)};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_valid      <= 1'b0;
      r1_sign       <= 1'b0;
      r1_match      <= 1'b0;
      r1_m_big      <= '0;
      r1_aligned    <= '0;
      r1_e_big      <= '0;
      r1_tag        <= '0;
      r2_valid      <= 1'b0;
      r2_sign       <= 1'b0;
      r2_sum        <= '0;
      r2_e_big      <= '0;
      r2_tag        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_res   <= '0;
      bus.out_tag   <= '0;
      bus.out_ovf   <= 1'b0;
      bus.out_unf   <= 1'b0;
      bus.out_zero  <= 1'b0;
    end else if (w_adv) begin
      r1_valid      <= bus.in_valid;
      r1_sign       <= w_a_big ? w_a_s : w_b_s;
      r1_match      <= w_a_s == w_b_s;
      r1_m_big      <= w_m_big;
      r1_aligned    <= w_aligned;
      r1_e_big      <= w_e_big;
      r1_tag        <= bus.in_tag;
      r2_valid      <= r1_valid;
      r2_sign       <= r1_sign;
      r2_sum        <= w_sum;
      r2_e_big      <= r1_e_big;
      r2_tag        <= r1_tag;
      bus.out_valid <= r2_valid;
      bus.out_res   <= w_res;
      bus.out_tag   <= r2_tag;
      bus.out_ovf   <= w_ovf;
      bus.out_unf   <= w_unf;
      bus.out_zero  <= w_exact | w_unf;
    end
  end
endmodule

// File: tb/tb_flop_add_pipe.sv
// tb_flop_add_pipe: scoreboard bench for the flop_add_pipe add/subtract pipeline
module tb_flop_add_pipe;
  localparam int MW = 8, EW = 4, TW = 4, W = 13;
  typedef struct packed {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    logic          ovf, unf, zero;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rnd_bp = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  flop_add_pipe_if #(.MANT_W(MW), .EXP_W(EW), .TAG_W(TW)) bus ();
  flop_add_pipe #(.MANT_W(MW), .EXP_W(EW), .TAG_W(TW)) dut (.clk(clk), .reset(reset), .bus(bus));
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic [TW-1:0] tag);
    int ma, ea, mb, eb, mbig, ebig, msm, esm, d, al, sum, lz;
    logic sa, sbx, sbig;
    exp_t e;
    e = '0;
    e.tag = tag;
    sa = a[W-1]; ma = int'(a[W-2:EW]); ea = int'(a[EW-1:0]);
    sbx = b[W-1] ^ sub; mb = int'(b[W-2:EW]); eb = int'(b[EW-1:0]);
    if (ea * 256 + ma >= eb * 256 + mb) begin
      sbig = sa; mbig = ma; ebig = ea; msm = mb; esm = eb;
    end else begin
      sbig = sbx; mbig = mb; ebig = eb; msm = ma; esm = ea;
    end
    d = ebig - esm;
    al = (d >= MW) ? 0 : (msm >> d);
    sum = (sa == sbx) ? mbig + al : mbig - al;
    if (sum == 0) e.zero = 1'b1;
    else if (sum >= 256) begin
      if (ebig == 15) begin e.ovf = 1'b1; e.res = {sbig, 12'hFFF}; end
      else e.res = {sbig, 8'(sum >> 1), 4'(ebig + 1)};
    end else begin
      lz = 0;
      while (sum < 128) begin sum = sum * 2; lz++; end
      if (lz > ebig) begin e.unf = 1'b1; e.zero = 1'b1; end
      else e.res = {sbig, 8'(sum), 4'(ebig - lz)};
    end
    return e;
  endfunction
  task automatic cycle();
    exp_t e, o;
    @(negedge clk);
    if (!reset && bus.in_valid && bus.in_ready) q.push_back(model(bus.in_a, bus.in_b, bus.in_sub, bus.in_tag));
    if (!reset && bus.out_valid && bus.out_ready) begin
      checks++;
      o = {bus.out_res, bus.out_tag, bus.out_ovf, bus.out_unf, bus.out_zero};
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_extra: got %h expected none", o);
      end else begin
        e = q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL scoreboard: got res=%h tag=%0d ovf=%b unf=%b zero=%b expected res=%h tag=%0d ovf=%b unf=%b zero=%b",
                   o.res, o.tag, o.ovf, o.unf, o.zero, e.res, e.tag, e.ovf, e.unf, e.zero);
        end
      end
    end
    @(posedge clk);
    #1;
    if (rnd_bp) bus.out_ready = $urandom_range(0, 3) != 0;
    #1;
  endtask
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic [TW-1:0] tag);
    int t;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_sub = sub; bus.in_tag = tag;
    t = 0;
    while (!bus.in_ready && t < 50) begin cycle(); t++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, t);
    end
    cycle();
    bus.in_valid = 1'b0;
  endtask
  task automatic exec(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic [TW-1:0] tag,
                      output int lat, output exp_t o);
    send(a, b, sub, tag);
    lat = 1;
    while (!bus.out_valid && lat < 10) begin cycle(); lat++; end
    o = {bus.out_res, bus.out_tag, bus.out_ovf, bus.out_unf, bus.out_zero};
    cycle();
  endtask
  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_res !== '0) begin errors++; $display("FAIL reset_res: got %h expected 000", bus.out_res); end
    checks++; if ({bus.out_tag, bus.out_ovf, bus.out_unf, bus.out_zero} !== '0) begin errors++;
      $display("FAIL reset_side: got tag=%0d flags=%b%b%b expected 0", bus.out_tag, bus.out_ovf, bus.out_unf, bus.out_zero); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk); #1;
    cycle();
    reset = 1'b0;
  endtask
  task automatic test_add();
    int lat; exp_t o;
    exec(13'h0803, 13'h0803, 1'b0, 4'd5, lat, o);
    checks++; if (lat !== 3) begin errors++; $display("FAIL add_latency: got %0d expected 3", lat); end
    checks++; if (o.res !== 13'h0804) begin errors++; $display("FAIL add_res: got %h expected 0804", o.res); end
    checks++; if (o.tag !== 4'd5) begin errors++; $display("FAIL add_tag: got %0d expected 5", o.tag); end
    checks++; if ({o.ovf, o.unf, o.zero} !== 3'b000) begin errors++; $display("FAIL add_flags: got %b expected 000", {o.ovf, o.unf, o.zero}); end
  endtask
  task automatic test_cancel();
    int lat; exp_t o;
    exec(13'h0803, 13'h0803, 1'b1, 4'd1, lat, o);
    checks++; if ({o.res, o.zero, o.ovf, o.unf} !== {13'h0000, 3'b100}) begin errors++;
      $display("FAIL cancel_sub: got res=%h zero=%b ovf=%b unf=%b expected 0000 1 0 0", o.res, o.zero, o.ovf, o.unf); end
    exec(13'h0803, 13'h1803, 1'b0, 4'd2, lat, o);
    checks++; if ({o.res, o.zero, o.ovf, o.unf} !== {13'h0000, 3'b100}) begin errors++;
      $display("FAIL cancel_neg: got res=%h zero=%b ovf=%b unf=%b expected 0000 1 0 0", o.res, o.zero, o.ovf, o.unf); end
  endtask
  task automatic test_overflow();
    int lat; exp_t o;
    exec(13'h0FFF, 13'h0FFF, 1'b0, 4'd3, lat, o);
    checks++; if ({o.res, o.ovf, o.zero} !== {13'h0FFF, 2'b10}) begin errors++;
      $display("FAIL ovf_pos: got res=%h ovf=%b zero=%b expected 0fff 1 0", o.res, o.ovf, o.zero); end
    exec(13'h1FFF, 13'h1FFF, 1'b0, 4'd4, lat, o);
    checks++; if ({o.res, o.ovf, o.zero} !== {13'h1FFF, 2'b10}) begin errors++;
      $display("FAIL ovf_neg: got res=%h ovf=%b zero=%b expected 1fff 1 0", o.res, o.ovf, o.zero); end
  endtask
  task automatic test_underflow();
    int lat; exp_t o;
    exec(13'h0801, 13'h0FF0, 1'b1, 4'd6, lat, o);
    checks++; if ({o.res, o.ovf, o.unf, o.zero} !== {13'h0000, 3'b011}) begin errors++;
      $display("FAIL unf: got res=%h ovf=%b unf=%b zero=%b expected 0000 0 1 1", o.res, o.ovf, o.unf, o.zero); end
  endtask
  task automatic test_back_to_back();
    int k, n; logic acc; logic [W-1:0] held_res; logic [TW-1:0] held_tag;
    int got[6]; int first, last;
    k = 0; n = 0; first = 0; last = 0; held_res = '0; held_tag = '0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = 13'h0803; bus.in_b = 13'h0803; bus.in_sub = 1'b0; bus.in_tag = '0;
    #1;
    for (int c = 0; c < 30; c++) begin
      if (c == 4) begin held_res = bus.out_res; held_tag = bus.out_tag; end
      if (c == 8) begin
        checks++; if (k !== 3) begin errors++; $display("FAIL bp_accepts: got %0d expected 3", k); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if ({bus.out_valid, bus.out_res, bus.out_tag} !== {1'b1, held_res, held_tag} || held_tag !== 4'd0) begin errors++;
          $display("FAIL bp_stable: got v=%b res=%h tag=%0d expected 1 %h 0", bus.out_valid, bus.out_res, bus.out_tag, held_res); end
        bus.out_ready = 1'b1;
        #1;
      end
      if (bus.out_valid && bus.out_ready && n < 6) begin
        got[n] = int'(bus.out_tag);
        if (n == 0) first = c;
        last = c;
        n++;
      end
      acc = bus.in_valid && bus.in_ready;
      cycle();
      if (acc) k++;
      bus.in_valid = k < 6;
      bus.in_tag = TW'(k);
    end
    checks++; if (n !== 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (got[i] !== i) begin errors++; $display("FAIL bp_order: got tag %0d expected %0d", got[i], i); end
    end
    checks++; if (last - first !== 5) begin errors++; $display("FAIL bp_rate: got span %0d expected 5", last - first); end
  endtask
  task automatic test_reset_flight();
    int lat, stale; exp_t o;
    bus.out_ready = 1'b1;
    send(13'h0803, 13'h0803, 1'b0, 4'd1);
    send(13'h0803, 13'h0803, 1'b0, 4'd2);
    cycle();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flight_valid: got %b expected 1", bus.out_valid); end
    reset = 1'b1;
    #1;
    checks++; if ({bus.out_valid, bus.out_res, bus.out_tag} !== '0) begin errors++;
      $display("FAIL flight_reset: got v=%b res=%h tag=%0d expected 0 0000 0", bus.out_valid, bus.out_res, bus.out_tag); end
    q.delete();
    @(posedge clk); #1;
    cycle();
    reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) stale++;
      cycle();
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL flight_stale: got %0d valid cycles expected 0", stale); end
    exec(13'h0803, 13'h0803, 1'b0, 4'd5, lat, o);
    checks++; if (lat !== 3 || o.res !== 13'h0804 || o.tag !== 4'd5) begin errors++;
      $display("FAIL flight_after: got lat=%0d res=%h tag=%0d expected 3 0804 5", lat, o.res, o.tag); end
  endtask
  task automatic test_random();
    int t;
    rnd_bp = 1'b1;
    for (int i = 0; i < 40; i++)
      send(W'($urandom), W'($urandom), 1'($urandom), TW'(i));
    rnd_bp = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    t = 0;
    while (q.size() > 0 && t < 30) begin cycle(); t++; end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL random_drain: got %0d pending expected 0", q.size()); end
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_sub = 1'b0; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    #1;
    test_reset();
    test_add();
    test_cancel();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_flight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end
endmodule
